mem_top: RTL and testbench

// - Synchronous single-port 4096 x 8 SRAM model with active-low chip enable and separate rd/wr strobes.
// - Standalone memory macro for checker/verification work; models supply-rail health through internal vdd/vss.
// - Never-written locations read as 8'h00.

---
 rtl/mem_top.sv | 46 ++++
 tb/tb_mem_top.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_top.sv
// mem_top: synchronous 4096x8 SRAM model with active-low cen, rd/wr strobes and per-word valid bits.
// Define POWER_CHECK_EN to gate all operations on internal vdd/vss rail health.
module mem_top #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 1 << ADDR_W,
    parameter int VDD_MIN_MV = 1750,
    parameter int VDD_MAX_MV = 1980
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    real vdd = 1.8;
    real vss = 0.0;
    logic              supply_ok;
    logic              op_ok;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DATA_W-1:0] dout_q;
`ifdef POWER_CHECK_EN
    assign supply_ok = (vdd * 1000.0 >= real'(VDD_MIN_MV)) && (vdd * 1000.0 <= real'(VDD_MAX_MV)) && (vss == 0.0);
`else
    logic unused_rails;
    assign unused_rails = (vdd != 0.0) || (vss != 0.0) || (VDD_MIN_MV > VDD_MAX_MV);
    assign supply_ok    = 1'b1;
`endif
    assign op_ok = ~cen & ~rst & supply_ok;
    // Array kept reset-free so it can map onto a RAM macro; valid bits carry the "never written" state.
    always_ff @(posedge clk)
        if (op_ok && wr && !rd) mem[add] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid  <= '0;
            dout_q <= '0;
        end else if (op_ok) begin
            if (wr && !rd) valid[add] <= 1'b1;
            else if (rd && !wr) dout_q <= valid[add] ? mem[add] : '0;
        end
    assign dout = (cen || !supply_ok) ? '0 : dout_q;
endmodule

// File: tb/tb_mem_top.sv
// tb_mem_top: randomized and directed checks of mem_top against a word-array reference model.
module tb_mem_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [11:0] add = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    int          hp = 500;
    int          checks = 0;
    int          passed = 0;
    int          ref_mem [4096];
    logic [7:0]  exp_q = '0;
    bit          rails_ok = 1'b1;

    mem_top dut (.clk(clk), .rst(rst), .cen(cen), .rd(rd), .wr(wr), .add(add), .din(din), .dout(dout));

    always #hp clk = ~clk;

    function automatic logic [7:0] exp_dout();
        return (cen || !rails_ok) ? 8'h00 : exp_q;
    endfunction

    task automatic clear_model();
        foreach (ref_mem[i]) ref_mem[i] = -1;
        exp_q = 8'h00;
    endtask

    // One clock of stimulus; the model applies the memory's rules after the edge.
    task automatic op(input logic c, input logic r, input logic w, input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        cen = c; rd = r; wr = w; add = a; din = d;
        @(posedge clk);
        #1;
        if (!c && rails_ok && (r ^ w)) begin
            if (w) ref_mem[a] = int'(d);
            else exp_q = (ref_mem[a] < 0) ? 8'h00 : 8'(ref_mem[a]);
        end
    endtask

    task automatic test_reset();
        clear_model();
        rst = 1'b1; cen = 1'b0;
        #800;
        checks++;
        if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout); else passed++;
        @(negedge clk);
        rst = 1'b0;
        op(0, 1, 0, 12'h2AA, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL reset_unwritten got=%h exp=00", dout); else passed++;
    endtask

    task automatic test_write_read();
        op(0, 0, 1, 12'h2AA, 8'hAA);
        op(0, 0, 1, 12'h6CA, 8'hEA);
        checks++;
        if (dout !== 8'h00) $display("FAIL write_holds_dout got=%h exp=00", dout); else passed++;
        op(0, 1, 0, 12'h6CA, 8'h00);
        checks++;
        if (dout !== 8'hEA) $display("FAIL read_6ca got=%h exp=ea", dout); else passed++;
        op(0, 0, 0, 12'h000, 8'h00);
        checks++;
        if (dout !== 8'hEA) $display("FAIL idle_hold got=%h exp=ea", dout); else passed++;
        op(0, 0, 1, 12'hEA8, 8'hBB);
        op(0, 0, 1, 12'hFAE, 8'hFE);
        op(0, 1, 0, 12'hEA8, 8'h00);
        checks++;
        if (dout !== 8'hBB) $display("FAIL read_ea8 got=%h exp=bb", dout); else passed++;
        op(0, 1, 0, 12'hFAE, 8'h00);
        checks++;
        if (dout !== 8'hFE) $display("FAIL read_fae got=%h exp=fe", dout); else passed++;
        op(0, 1, 0, 12'hFAD, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL read_unwritten_fad got=%h exp=00", dout); else passed++;
        op(0, 0, 1, 12'hFFF, 8'h3C);
        op(0, 1, 0, 12'hFFF, 8'h00);
        checks++;
        if (dout !== 8'h3C) $display("FAIL read_last_word got=%h exp=3c", dout); else passed++;
    endtask

    task automatic test_cen();
        op(0, 1, 0, 12'hEA8, 8'h00);
        op(1, 0, 1, 12'hFAE, 8'h11);
        checks++;
        if (dout !== 8'h00) $display("FAIL cen_write_mask got=%h exp=00", dout); else passed++;
        op(1, 1, 0, 12'hFAE, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL cen_read_mask got=%h exp=00", dout); else passed++;
        op(0, 0, 0, 12'hFAE, 8'h00);
        checks++;
        if (dout !== 8'hBB) $display("FAIL cen_retained_q got=%h exp=bb", dout); else passed++;
        op(0, 1, 0, 12'hFAE, 8'h00);
        checks++;
        if (dout !== 8'hFE) $display("FAIL cen_write_blocked got=%h exp=fe", dout); else passed++;
    endtask

    task automatic test_illegal();
        op(0, 1, 1, 12'h2AA, 8'h55);
        checks++;
        if (dout !== 8'hFE) $display("FAIL rdwr_dout_hold got=%h exp=fe", dout); else passed++;
        op(0, 1, 0, 12'h2AA, 8'h00);
        checks++;
        if (dout !== 8'hAA) $display("FAIL rdwr_no_write got=%h exp=aa", dout); else passed++;
    endtask

    task automatic test_power();
`ifdef POWER_CHECK_EN
        dut.vdd = 1.7; rails_ok = 1'b0;
        op(0, 0, 1, 12'h6CA, 8'hAA);
        checks++;
        if (dout !== 8'h00) $display("FAIL power_low_dout got=%h exp=00", dout); else passed++;
        op(0, 1, 0, 12'h6CA, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL power_low_read got=%h exp=00", dout); else passed++;
        dut.vdd = 1.8; rails_ok = 1'b1;
        #1;
        checks++;
        if (dout !== 8'hAA) $display("FAIL power_restore_q got=%h exp=aa", dout); else passed++;
        op(0, 1, 0, 12'h6CA, 8'h00);
        checks++;
        if (dout !== 8'hEA) $display("FAIL power_write_blocked got=%h exp=ea", dout); else passed++;
`else
        dut.vdd = 1.7;
        op(0, 0, 1, 12'h100, 8'h77);
        op(0, 1, 0, 12'h100, 8'h00);
        checks++;
        if (dout !== 8'h77) $display("FAIL rails_ignored got=%h exp=77", dout); else passed++;
        dut.vdd = 1.8;
`endif
    endtask

    task automatic test_random();
        logic [11:0] pool [8];
        logic        c, r, w;
        pool = '{12'h000, 12'hFFF, 12'h2AA, 12'h6CA, 12'hEA8, 12'hFAE, 12'hFAD, 12'h123};
        @(negedge clk);
        hp = 100;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 1) == 1;
            w = $urandom_range(0, 2) == 0;
            op(c, r, w, pool[$urandom_range(0, 7)], 8'($urandom));
            checks++;
            if (dout !== exp_dout()) $display("FAIL random_op%0d got=%h exp=%h", i, dout, exp_dout()); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        op(0, 0, 1, 12'h6CA, 8'hEA);
        op(0, 1, 0, 12'h6CA, 8'h00);
        checks++;
        if (dout !== 8'hEA) $display("FAIL pre_reset_read got=%h exp=ea", dout); else passed++;
        @(negedge clk);
        cen = 1'b0; rd = 1'b1; wr = 1'b0; add = 12'h6CA;
        #(hp / 2);
        rst = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) $display("FAIL async_reset_dout got=%h exp=00", dout); else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h00) $display("FAIL reset_held got=%h exp=00", dout); else passed++;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        op(0, 1, 0, 12'h6CA, 8'h00);
        checks++;
        if (dout !== 8'h00) $display("FAIL valid_cleared_6ca got=%h exp=00", dout); else passed++;
        op(0, 0, 1, 12'h6CA, 8'h5A);
        op(0, 1, 0, 12'h6CA, 8'h00);
        checks++;
        if (dout !== 8'h5A) $display("FAIL post_reset_write got=%h exp=5a", dout); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_cen();
        test_illegal();
        test_power();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
